// File: rtl/pll_rate_ctrl_pkg.sv
// Shared encodings and default timing for the PHY PLL rate sequencer.
package pll_ctrl_pkg;

    localparam logic [2:0] ST_OFF       = 3'd0;
    localparam logic [2:0] ST_PWR_UP    = 3'd1;
    localparam logic [2:0] ST_WAIT_LOCK = 3'd2;
    localparam logic [2:0] ST_SETTLE    = 3'd3;
    localparam logic [2:0] ST_READY     = 3'd4;
    localparam logic [2:0] ST_RATE_CHG  = 3'd5;
    localparam logic [2:0] ST_ERROR     = 3'd6;

    localparam int unsigned DEF_RATE_W       = 2;
    localparam int unsigned DEF_RST_CYC      = 4;
    localparam int unsigned DEF_LOCK_TIMEOUT = 64;
    localparam int unsigned DEF_SETTLE_CYC   = 8;
    localparam int unsigned DEF_CNT_W        = 8;

endpackage

// File: rtl/pll_rate_ctrl_if.sv
// Control/status bundle between the PLL sequencer and the PHY top / PLL macro.
interface pll_rate_ctrl_if #(
    parameter int unsigned RATE_W = 2
);
    logic              Pll_Req;
    logic [RATE_W-1:0] Rate;
    logic              Pll_Locked;
    logic              Pll_Rst;
    logic              Pll_En;
    logic [RATE_W-1:0] Div_Sel;
    logic              Clk_Gate_En;
    logic              PhyStatus;
    logic              Lock_Err;
    logic [2:0]        State;

    // master: the sequencer; slave: the PHY top and PLL it controls
    modport master (
        input  Pll_Req, Rate, Pll_Locked,
        output Pll_Rst, Pll_En, Div_Sel, Clk_Gate_En, PhyStatus, Lock_Err, State
    );
    modport slave (
        output Pll_Req, Rate, Pll_Locked,
        input  Pll_Rst, Pll_En, Div_Sel, Clk_Gate_En, PhyStatus, Lock_Err, State
    );
endinterface

// File: rtl/pll_rate_ctrl_sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs, synchronous reset to 0.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/pll_rate_ctrl.sv
// PLL bring-up / rate-change sequencer on Ref_Clk: reset, lock wait, lock
// qualification, clock gating and PhyStatus completion reporting.
module pll_rate_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int unsigned RATE_W       = DEF_RATE_W,
    parameter int unsigned RST_CYC      = DEF_RST_CYC,
    parameter int unsigned LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
    parameter int unsigned SETTLE_CYC   = DEF_SETTLE_CYC,
    parameter int unsigned CNT_W        = DEF_CNT_W
) (
    input logic             Ref_Clk,
    input logic             Rst,
    pll_rate_ctrl_if.master bus
);
    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

    logic              lk_s;
    logic [2:0]        st_q, st_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [RATE_W-1:0] div_q, div_d;
    logic              err_q, err_d;
    logic              pll_rst_q, pll_en_q, gate_q, phy_q;

    sync_2ff #(.WIDTH(1)) u_lock_sync (
        .clk_i (Ref_Clk),
        .rst_i (Rst),
        .d_i   (bus.Pll_Locked),
        .q_o   (lk_s)
    );

    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        st_d  = st_q;
        cnt_d = cnt_q;
        div_d = div_q;
        err_d = err_q;
        case (st_q)
            ST_OFF: begin
                if (bus.Pll_Req) begin
                    st_d  = ST_PWR_UP;
                    cnt_d = '0;
                    div_d = bus.Rate;
                    err_d = 1'b0;
                end
            end
            ST_PWR_UP: begin
                if (cnt_q == RST_LAST) begin
                    st_d  = ST_WAIT_LOCK;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_WAIT_LOCK: begin
                if (lk_s) begin
                    st_d  = ST_SETTLE;
                    cnt_d = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    st_d  = ST_ERROR;
                    err_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_SETTLE: begin
                if (!lk_s) begin
                    st_d  = ST_WAIT_LOCK;
                    cnt_d = '0;
                end else if (cnt_q == SETTLE_LAST) begin
                    st_d = ST_READY;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_READY: begin
                if (!lk_s) begin
                    st_d  = ST_WAIT_LOCK;
                    cnt_d = '0;
                end else if (bus.Rate != div_q) begin
                    st_d = ST_RATE_CHG;
                end
            end
            ST_RATE_CHG: begin
                st_d  = ST_PWR_UP;
                cnt_d = '0;
                div_d = bus.Rate;
            end
            ST_ERROR: begin
                if (!bus.Pll_Req) begin
                    st_d = ST_OFF;
                end
            end
            default: st_d = ST_OFF;
        endcase
        // Power-down request wins over every transition except from OFF/ERROR
        if (!bus.Pll_Req && st_q != ST_OFF && st_q != ST_ERROR) begin
            st_d  = ST_OFF;
            cnt_d = '0;
        end
    end

    // Outputs are decoded from the next state so they line up with State
    always_ff @(posedge Ref_Clk) begin
        if (Rst) begin
            st_q      <= ST_OFF;
            cnt_q     <= '0;
            div_q     <= '0;
            err_q     <= 1'b0;
            pll_rst_q <= 1'b1;
            pll_en_q  <= 1'b0;
            gate_q    <= 1'b0;
            phy_q     <= 1'b0;
        end else begin
            st_q      <= st_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            err_q     <= err_d;
            pll_rst_q <= (st_d == ST_OFF) || (st_d == ST_PWR_UP) || (st_d == ST_ERROR);
            pll_en_q  <= (st_d != ST_OFF) && (st_d != ST_ERROR);
            gate_q    <= (st_d == ST_READY);
            phy_q     <= (st_d == ST_READY) && (st_q == ST_SETTLE);
        end
    end

    assign bus.Pll_Rst     = pll_rst_q;
    assign bus.Pll_En      = pll_en_q;
    assign bus.Div_Sel     = div_q;
    assign bus.Clk_Gate_En = gate_q;
    assign bus.PhyStatus   = phy_q;
    assign bus.Lock_Err    = err_q;
    assign bus.State       = st_q;
endmodule

// File: tb/tb_pll_rate_ctrl.sv
// Bench for pll_rate_ctrl: event times predicted from the sequencing rules,
// observed events popped from a queue by an independent monitor.
module tb_pll_rate_ctrl;
    localparam int RST_CYC      = 4;
    localparam int LOCK_TIMEOUT = 64;
    localparam int SETTLE_CYC   = 8;
    localparam int SYNC_LAG     = 3;   // pin driven after edge p is acted on at edge p+3

    localparam int K_RSTFALL = 0;
    localparam int K_PHY     = 1;
    localparam int K_ERR     = 2;
    localparam int K_GATEOFF = 3;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;
    int   cur_rate;

    typedef struct {
        int kind;
        int cyc;
        int val;
    } ev_t;
    ev_t exp_q[$];

    pll_rate_ctrl_if #(.RATE_W(2)) bus ();

    pll_rate_ctrl #(
        .RATE_W       (2),
        .RST_CYC      (RST_CYC),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .SETTLE_CYC   (SETTLE_CYC),
        .CNT_W        (8)
    ) dut (
        .Ref_Clk (clk),
        .Rst     (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic push(input int kind, input int c, input int val);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic got(input int kind, input int val);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL unexpected_event kind=%0d at cycle %0d value %0d, expected none", kind, cyc, val);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", kind, e.kind);
            chk("event_cycle", cyc, e.cyc);
            chk("event_value", val, e.val);
        end
    endtask

    // Monitor: edges of the observable outputs are the events
    logic p_rst = 1'b1, p_err = 1'b0, p_gate = 1'b0;
    always @(negedge clk) begin
        if (cyc >= 1) begin
            if (bus.PhyStatus === 1'b1)
                got(K_PHY, int'(bus.Div_Sel) * 8 + int'(bus.State));
            if (p_rst === 1'b1 && bus.Pll_Rst === 1'b0)
                got(K_RSTFALL, int'(bus.State));
            if (p_err === 1'b0 && bus.Lock_Err === 1'b1)
                got(K_ERR, int'(bus.State));
            if (p_gate === 1'b1 && bus.Clk_Gate_En === 1'b0)
                got(K_GATEOFF, int'(bus.State));
            p_rst  = bus.Pll_Rst;
            p_err  = bus.Lock_Err;
            p_gate = bus.Clk_Gate_En;
        end
    end

    task automatic goto(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic obs(input int t);
        goto(t);
        @(negedge clk);
    endtask

    task automatic chk_off(input string name);
        chk({name, "_state"}, bus.State, 0);
        chk({name, "_flags"}, {bus.Pll_Rst, bus.Pll_En, bus.Clk_Gate_En, bus.PhyStatus, bus.Lock_Err}, 5'b10000);
    endtask

    // Lock rises after edge p once WAIT_LOCK was entered at w; optional glitch
    // at settle count gc. Completion is 8 clean cycles after the last detection.
    task automatic relock(input int w, input int p, input int gc, input int rate);
        int d, g, rdy;
        goto(p);
        bus.Pll_Locked = 1'b1;
        d = (p + SYNC_LAG > w + 1) ? p + SYNC_LAG : w + 1;
        if (gc >= 0) begin
            g = d + 1 + gc - SYNC_LAG;
            d = g + 1 + SYNC_LAG;
        end
        rdy = d + SETTLE_CYC;
        push(K_PHY, rdy, rate * 8 + 4);
        if (gc >= 0) begin
            goto(g);
            bus.Pll_Locked = 1'b0;
            goto(g + 1);
            bus.Pll_Locked = 1'b1;
        end
        obs(rdy + 1);
        chk("ready_state", bus.State, 4);
        chk("ready_gate", bus.Clk_Gate_En, 1);
        chk("phystatus_single", bus.PhyStatus, 0);
    endtask

    task automatic rate_change(input int gc);
        int t, nr;
        t = cyc + 1 + $urandom_range(0, 4);
        goto(t);
        nr = (cur_rate + 1 + $urandom_range(0, 2)) % 4;
        bus.Rate = nr[1:0];
        push(K_GATEOFF, t + 1, 5);
        push(K_RSTFALL, t + 2 + RST_CYC, 2);
        obs(t + 1);
        chk("ratechg_state", bus.State, 5);
        chk("ratechg_old_div", bus.Div_Sel, cur_rate);
        obs(t + 2);
        chk("ratechg_new_div", bus.Div_Sel, nr);
        chk("ratechg_pll_rst", bus.Pll_Rst, 1);
        bus.Pll_Locked = 1'b0;
        cur_rate = nr;
        relock(t + 2 + RST_CYC, t + 3 + $urandom_range(0, 12), gc, nr);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, w, e, q, t;
        rst = 1'b1;
        bus.Pll_Req = 1'b0;
        bus.Rate = '0;
        bus.Pll_Locked = 1'b0;

        // Reset and idle
        goto(3);
        rst = 1'b0;
        obs(3);
        chk_off("reset");
        chk("reset_div", bus.Div_Sel, 0);
        for (int c = 4; c <= 10; c++) begin
            obs(c);
            chk_off("idle");
        end

        // Bring-up, lock 10 cycles after Pll_Rst falls
        goto(11);
        cur_rate = $urandom_range(0, 3);
        bus.Rate = cur_rate[1:0];
        bus.Pll_Req = 1'b1;
        a = cyc + 1;
        w = a + RST_CYC;
        push(K_RSTFALL, w, 2);
        obs(a);
        chk("pwrup_state", bus.State, 1);
        chk("pwrup_en_rst", {bus.Pll_En, bus.Pll_Rst}, 2'b11);
        chk("pwrup_div", bus.Div_Sel, cur_rate);
        obs(w - 1);
        chk("pwrup_rst_held", bus.Pll_Rst, 1);
        relock(w, w + 10, -1, cur_rate);

        // Rate changes, including a glitch at settle count 5 and random ones
        for (int i = 0; i < 4; i++) begin
            if (i == 1)
                rate_change(5);
            else if ($urandom_range(0, 1) == 1)
                rate_change($urandom_range(0, 7));
            else
                rate_change(-1);
        end

        // Power-down from READY
        q = cyc + 1;
        goto(q);
        bus.Pll_Req = 1'b0;
        bus.Pll_Locked = 1'b0;
        push(K_GATEOFF, q + 1, 0);
        obs(q + 1);
        chk_off("pwrdn");

        // Lock timeout
        goto(q + 5);
        bus.Pll_Req = 1'b1;
        a = cyc + 1;
        w = a + RST_CYC;
        push(K_RSTFALL, w, 2);
        push(K_ERR, w + LOCK_TIMEOUT, 6);
        obs(w + LOCK_TIMEOUT - 1);
        chk("timeout_edge_state", bus.State, 2);
        chk("timeout_edge_err", bus.Lock_Err, 0);
        e = w + LOCK_TIMEOUT;
        obs(e);
        chk("error_state", bus.State, 6);
        chk("error_en_rst", {bus.Pll_En, bus.Pll_Rst}, 2'b01);
        chk("error_flag", bus.Lock_Err, 1);
        bus.Pll_Req = 1'b0;
        bus.Pll_Locked = 1'b1;
        obs(e + 1);
        chk("err_off_state", bus.State, 0);
        chk("err_sticky", bus.Lock_Err, 1);

        // Restart clears Lock_Err
        goto(e + 3);
        cur_rate = $urandom_range(0, 3);
        bus.Rate = cur_rate[1:0];
        bus.Pll_Req = 1'b1;
        a = e + 4;
        w = a + RST_CYC;
        push(K_RSTFALL, w, 2);
        obs(a);
        chk("restart_state", bus.State, 1);
        chk("restart_err_clr", bus.Lock_Err, 0);
        relock(w, e, -1, cur_rate);

        // Reset in the middle of RATE_CHG
        t = cyc + 1 + $urandom_range(0, 3);
        goto(t);
        bus.Rate = 2'((cur_rate + 1) % 4);
        push(K_GATEOFF, t + 1, 5);
        obs(t + 1);
        chk("pre_reset_state", bus.State, 5);
        rst = 1'b1;
        bus.Pll_Req = 1'b0;
        obs(t + 2);
        chk_off("midreset");
        chk("midreset_div", bus.Div_Sel, 0);
        goto(t + 3);
        rst = 1'b0;
        obs(t + 10);
        chk_off("post_reset");

        chk("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/pll_rate_ctrl.md
Name: pll_rate_ctrl

Overview:
Sequencer for the PHY PLL (Bit_Rate_Clk, Bit_Rate_CLK_10 and PCLK generator).
- Brings the PLL out of reset and waits for lock, then qualifies lock stability before enabling the downstream clocks.
- Handles rate (divider) changes and lock loss, and reports completion via a PIPE-style PhyStatus pulse.
- Runs on Ref_Clk, beside the PLL, under the PHY top.

Parameters:
RATE_W, 2, width of the rate/divider select
RST_CYC, 4, number of Ref_Clk cycles Pll_Rst is held after each (re)start
LOCK_TIMEOUT, 64, max cycles in WAIT_LOCK before error
SETTLE_CYC, 8, consecutive cycles lock must stay high before READY
CNT_W, 8, internal counter width; must hold max(RST_CYC, LOCK_TIMEOUT, SETTLE_CYC)

Ports:
Ref_Clk  in  1  reference clock; all logic is on its rising edge
Rst  in  1  reset, synchronous, active-high
Pll_Req  in  1  1 = PLL requested on, 0 = power down
Rate  in  RATE_W  requested rate; sampled only in READY
Pll_Locked  in  1  asynchronous lock indicator from the PLL
Pll_Rst  out  1  PLL reset, active-high
Pll_En  out  1  PLL enable
Div_Sel  out  RATE_W  divider select to the PLL
Clk_Gate_En  out  1  enables Bit_Rate_Clk and PCLK to consumers
PhyStatus  out  1  one-cycle done pulse
Lock_Err  out  1  sticky timeout flag
State  out  3  current FSM state, for debug

Behaviour:
- Reset (Rst=1 at a clock edge):
  - State=OFF, Pll_Rst=1, Pll_En=0, Div_Sel=0, Clk_Gate_En=0, PhyStatus=0, Lock_Err=0.
  - Counter=0; synchronizer flops=0.
  - Rst mid-operation aborts any state the same way.
- Pll_Locked passes through a 2-flop synchronizer (lk_s). All "lock" references below mean lk_s, which lags the pin by 2 cycles.
- State encoding (stored in a shared package): OFF=0, PWR_UP=1, WAIT_LOCK=2, SETTLE=3, READY=4, RATE_CHG=5, ERROR=6.
- OFF:
  - Pll_En=0, Pll_Rst=1, Clk_Gate_En=0.
  - Pll_Req=1 -> PWR_UP with counter cleared, Div_Sel<=Rate.
- PWR_UP:
  - Pll_En=1, Pll_Rst=1.
  - Counter counts RST_CYC cycles, then -> WAIT_LOCK with counter cleared.
- WAIT_LOCK:
  - Pll_Rst=0.
  - lock=1 -> SETTLE (counter cleared).
  - Counter reaching LOCK_TIMEOUT-1 without lock -> ERROR, Lock_Err<=1.
- SETTLE:
  - Counter increments while lock=1.
  - Lock drops -> back to WAIT_LOCK with counter cleared. The timeout restarts from zero.
  - SETTLE_CYC consecutive lock cycles -> READY, with PhyStatus=1 for exactly the first READY cycle.
- READY:
  - Clk_Gate_En=1.
  - Priority, highest first: Pll_Req=0 -> OFF; lock=0 -> WAIT_LOCK (Clk_Gate_En drops the next cycle, no PhyStatus); Rate!=Div_Sel -> RATE_CHG.
- RATE_CHG:
  - Clk_Gate_En=0 on entry.
  - Exactly one cycle later, Div_Sel<=Rate and Pll_Rst pulses via PWR_UP, then the normal re-lock path runs.
  - Completion is signalled by the PhyStatus pulse on re-entering READY.
  - Rate changes while not in READY are ignored until READY is reached.
- ERROR:
  - Pll_En=0, Pll_Rst=1.
  - Stays until Pll_Req=0, then goes to OFF.
  - Lock_Err clears only on Rst or on a new OFF->PWR_UP transition.
- Pll_Req=0 in any state except OFF/ERROR -> OFF next cycle; this overrides every other transition.
- Counter saturates, never wraps. All outputs are registered.

Decomposition:
- Package pll_ctrl_pkg holds the state encoding constants and the default timing constants.
- One sub-module, sync_2ff: a 2-flop synchronizer, parameterised width, reset to 0.

Test Plan:
1. Rst high 3 cycles, then low, with Pll_Req=0 -> State=OFF, Pll_Rst=1, all other outputs 0 indefinitely.
2. Pll_Req=1, Pll_Locked rises 10 cycles after Pll_Rst falls -> Pll_Rst high for 4 cycles; Clk_Gate_En=1 and a single-cycle PhyStatus exactly 2+8 cycles after the lock rise.
3. Pll_Locked held 0 -> after 64 WAIT_LOCK cycles Lock_Err=1, State=ERROR, Pll_En=0. Dropping Pll_Req then gives OFF.
4. In READY, Rate 0->2 -> Clk_Gate_En=0 next cycle; Div_Sel=2; Pll_Rst pulses 4 cycles; after re-lock and settle, one PhyStatus pulse.
5. Lock glitch low for 1 cycle during SETTLE at count 5 -> returns to WAIT_LOCK; READY only after 8 fresh consecutive lock cycles.
6. Rst asserted while in RATE_CHG -> next edge all outputs return to their reset values and State=OFF.
